// File: rtl/vc_arbiter_if.sv
// Signal bundle between the VC FIFO read side / downstream demux and vc_arbiter.
// Grant counters exist only when VC_ARB_STATS_EN is defined.
interface vc_arbiter_if #(
    parameter int unsigned DataWidth   = 6,
    parameter int unsigned WeightWidth = 4
);
    logic                   init;
    logic [WeightWidth-1:0] weight_in;
    logic                   empty_VC0;
    logic                   empty_VC1;
    logic [DataWidth-1:0]   data_VC0;
    logic [DataWidth-1:0]   data_VC1;
    logic                   almost_full_D0;
    logic                   almost_full_D1;
    logic                   pop_VC0;
    logic                   pop_VC1;
    logic [DataWidth-1:0]   data_out;
    logic                   valid_out;
    logic [1:0]             state_out;
    logic                   idle_out;
`ifdef VC_ARB_STATS_EN
    logic [7:0]             grant_cnt_VC0;
    logic [7:0]             grant_cnt_VC1;
`endif

    modport master (
        output init, weight_in, empty_VC0, empty_VC1, data_VC0, data_VC1,
        output almost_full_D0, almost_full_D1,
        input  pop_VC0, pop_VC1, data_out, valid_out, state_out, idle_out
`ifdef VC_ARB_STATS_EN
        , input grant_cnt_VC0, grant_cnt_VC1
`endif
    );

    modport slave (
        input  init, weight_in, empty_VC0, empty_VC1, data_VC0, data_VC1,
        input  almost_full_D0, almost_full_D1,
        output pop_VC0, pop_VC1, data_out, valid_out, state_out, idle_out
`ifdef VC_ARB_STATS_EN
        , output grant_cnt_VC0, grant_cnt_VC1
`endif
    );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler popping the VC0/VC1 FIFOs (VC0 favoured), 1-cycle output pipe.
// Optional per-VC grant counters are enabled with the VC_ARB_STATS_EN macro.
module vc_arbiter #(
    parameter int unsigned DataWidth   = 6,
    parameter int unsigned WeightWidth = 4
) (
    input  logic         clk,
    input  logic         reset,
    vc_arbiter_if.slave  io_vc
);
    typedef enum logic [1:0] {
        StReset  = 2'd0,
        StInit   = 2'd1,
        StIdle   = 2'd2,
        StActive = 2'd3
    } state_e;

    state_e                 r_state, w_state_next;
    logic [WeightWidth-1:0] r_cnt, w_cnt_next;
    logic [WeightWidth-1:0] r_w;
    logic                   r_vld, r_sel;
    logic [DataWidth-1:0]   r_data, w_data_mux;
    logic                   w_pause, w_can_grant, w_pop0, w_pop1, w_grant;
    logic                   w_any0, w_any1;

    always_comb begin
        w_pause     = io_vc.almost_full_D0 | io_vc.almost_full_D1;
        w_any0      = ~io_vc.empty_VC0;
        w_any1      = ~io_vc.empty_VC1;
        w_can_grant = reset && !io_vc.init && !w_pause &&
                      (r_state == StIdle || r_state == StActive);
        w_pop0      = 1'b0;
        w_pop1      = 1'b0;
        // VC0 wins until it has had w consecutive grants while VC1 is waiting.
        if (w_can_grant) begin
            if (w_any0 && (!w_any1 || r_cnt < r_w)) w_pop0 = 1'b1;
            else if (w_any1)                        w_pop1 = 1'b1;
        end
        w_grant = w_pop0 | w_pop1;

        w_cnt_next = r_cnt;
        if (w_pop0)      w_cnt_next = (r_cnt >= r_w) ? r_w : r_cnt + 1'b1;
        else if (w_pop1) w_cnt_next = '0;

        w_state_next = r_state;
        unique case (r_state)
            StReset:  w_state_next = StInit;
            StInit:   if (!io_vc.init) w_state_next = StIdle;
            StIdle: begin
                if (io_vc.init)   w_state_next = StInit;
                else if (w_grant) w_state_next = StActive;
            end
            StActive: begin
                if (io_vc.init)                        w_state_next = StInit;
                else if (!w_any0 && !w_any1 && !w_grant) w_state_next = StIdle;
            end
            default:  w_state_next = StReset;
        endcase
        if (w_state_next == StInit) w_cnt_next = '0;

        w_data_mux = r_sel ? io_vc.data_VC1 : io_vc.data_VC0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StReset;
            r_cnt   <= '0;
            r_w     <= WeightWidth'(1);
            r_vld   <= 1'b0;
            r_sel   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == StInit && io_vc.init) begin
                r_w <= (io_vc.weight_in == '0) ? WeightWidth'(1) : io_vc.weight_in;
            end
            r_vld <= w_grant;
            r_sel <= w_pop1;
            if (r_vld) r_data <= w_data_mux;
        end
    end

    assign io_vc.pop_VC0   = w_pop0;
    assign io_vc.pop_VC1   = w_pop1;
    assign io_vc.valid_out = r_vld;
    assign io_vc.data_out  = r_vld ? w_data_mux : r_data;
    assign io_vc.state_out = r_state;
    assign io_vc.idle_out  = (r_state == StIdle);

`ifdef VC_ARB_STATS_EN
    logic [7:0] r_gcnt0, r_gcnt1;

    always_ff @(posedge clk) begin
        if (!reset || w_state_next == StInit) begin
            r_gcnt0 <= 8'd0;
            r_gcnt1 <= 8'd0;
        end else begin
            if (w_pop0 && r_gcnt0 != 8'hFF) r_gcnt0 <= r_gcnt0 + 8'd1;
            if (w_pop1 && r_gcnt1 != 8'hFF) r_gcnt1 <= r_gcnt1 + 8'd1;
        end
    end

    assign io_vc.grant_cnt_VC0 = r_gcnt0;
    assign io_vc.grant_cnt_VC1 = r_gcnt1;
`endif
endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: directed plan steps then random traffic vs. a FIFO/scheduler model.
module tb_vc_arbiter;
    localparam int unsigned Dw = 6;
    localparam int unsigned Ww = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vc_arbiter_if #(.DataWidth(Dw), .WeightWidth(Ww)) vif ();

    vc_arbiter #(.DataWidth(Dw), .WeightWidth(Ww)) dut (
        .clk   (clk),
        .reset (reset),
        .io_vc (vif)
    );

    int n_chk = 0;
    int n_err = 0;

    // Environment + reference model
    logic [Dw-1:0] q0[$];
    logic [Dw-1:0] q1[$];
    logic [Dw-1:0] d0 = '0, d1 = '0;
    int            m_state = 0, m_cnt = 0, m_w = 1, m_g0 = 0, m_g1 = 0;
    bit            m_vld = 0, m_sel = 0;
    logic [Dw-1:0] m_data = '0;
    bit            last_p0, last_p1;
    int            pop_seq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit e0, e1, ok, p0, p1, vc1_turn;
        int ns;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        vif.empty_VC0 = e0;
        vif.empty_VC1 = e1;
        #1;
        ok = reset && !vif.init && (m_state >= 2) &&
             !(vif.almost_full_D0 || vif.almost_full_D1);
        // VC1 gets its turn once VC0 has used up its weight of consecutive grants.
        vc1_turn = (m_cnt >= m_w);
        p0 = ok && !e0 && (e1 || !vc1_turn);
        p1 = ok && !e1 && (e0 || vc1_turn);
        chk("pop_VC0", vif.pop_VC0, p0);
        chk("pop_VC1", vif.pop_VC1, p1);
        last_p0 = p0;
        last_p1 = p1;
        if (p0) pop_seq.push_back(0);
        if (p1) pop_seq.push_back(1);
        @(posedge clk);
        #1;
        if (!reset) begin
            m_state = 0; m_cnt = 0; m_w = 1; m_vld = 0; m_sel = 0; m_data = '0;
            m_g0 = 0; m_g1 = 0;
        end else begin
            if (m_vld) m_data = m_sel ? d1 : d0;
            case (m_state)
                0:       ns = 1;
                1:       ns = vif.init ? 1 : 2;
                2:       ns = vif.init ? 1 : ((p0 || p1) ? 3 : 2);
                default: ns = vif.init ? 1 : ((e0 && e1) ? 2 : 3);
            endcase
            if (m_state == 1 && vif.init) m_w = (vif.weight_in == 0) ? 1 : int'(vif.weight_in);
            if (p0) begin
                m_cnt = (m_cnt + 1 > m_w) ? m_w : m_cnt + 1;
                d0 = q0.pop_front();
                if (m_g0 < 255) m_g0++;
            end
            if (p1) begin
                m_cnt = 0;
                d1 = q1.pop_front();
                if (m_g1 < 255) m_g1++;
            end
            if (ns == 1) begin
                m_cnt = 0; m_g0 = 0; m_g1 = 0;
            end
            m_state = ns;
            m_vld   = p0 || p1;
            m_sel   = p1;
        end
        vif.data_VC0 = d0;
        vif.data_VC1 = d1;
        #1;
        chk("valid_out", vif.valid_out, m_vld);
        chk("data_out", vif.data_out, m_vld ? (m_sel ? d1 : d0) : m_data);
        chk("state_out", vif.state_out, m_state);
        chk("idle_out", vif.idle_out, m_state == 2);
`ifdef VC_ARB_STATS_EN
        chk("grant_cnt_VC0", vif.grant_cnt_VC0, m_g0);
        chk("grant_cnt_VC1", vif.grant_cnt_VC1, m_g1);
`endif
    endtask

    task automatic push(input int n0, input int n1);
        for (int i = 0; i < n0; i++) q0.push_back(Dw'($urandom));
        for (int i = 0; i < n1; i++) q1.push_back(Dw'($urandom));
    endtask

    task automatic configure(input int wt);
        vif.init      = 1'b1;
        vif.weight_in = Ww'(wt);
        step();
        step();
        vif.init = 1'b0;
        step();
    endtask

    initial begin
        reset              = 1'b0;
        vif.init           = 1'b0;
        vif.weight_in      = '0;
        vif.almost_full_D0 = 1'b0;
        vif.almost_full_D1 = 1'b0;
        vif.data_VC0       = '0;
        vif.data_VC1       = '0;
        vif.empty_VC0      = 1'b1;
        vif.empty_VC1      = 1'b1;

        // Reset then INIT with weight 3: states 0,0,1,1,2
        step();
        step();
        chk("reset_state", vif.state_out, 0);
        reset         = 1'b1;
        vif.init      = 1'b1;
        vif.weight_in = 4'd3;
        step();
        chk("init_state_a", vif.state_out, 1);
        step();
        chk("init_state_b", vif.state_out, 1);
        vif.init = 1'b0;
        step();
        chk("idle_state", vif.state_out, 2);

        // Weighted arbitration, w=3
        push(8, 8);
        pop_seq.delete();
        for (int i = 0; i < 18; i++) step();
        for (int i = 0; i < 8; i++) chk("wrr_order", pop_seq[i], (i % 4 == 3) ? 1 : 0);
        chk("wrr_total", pop_seq.size(), 16);

        // Single-VC1 stream, w=2
        configure(2);
        push(0, 4);
        pop_seq.delete();
        for (int i = 0; i < 6; i++) step();
        chk("vc1_pops", pop_seq.size(), 4);
        chk("vc1_idle", vif.idle_out, 1);

        // Pause mid-stream on D1
        push(6, 6);
        step();
        step();
        vif.almost_full_D1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_nopop", {last_p0, last_p1}, 2'b00);
        end
        vif.almost_full_D1 = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Weight 0 stored as 1; VC0 alone saturates cnt, so VC1 goes next
        configure(0);
        push(5, 0);
        for (int i = 0; i < 6; i++) step();
        push(1, 1);
        step();
        chk("sat_vc1_first", last_p1, 1);
        step();
        step();

        // Reset mid-stream
        push(4, 4);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_valid", vif.valid_out, 0);
        step();
        reset = 1'b1;
        configure(3);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 12 && $urandom_range(0, 2) == 0) push(1, 0);
            if (q1.size() < 12 && $urandom_range(0, 2) == 0) push(0, 1);
            vif.almost_full_D0 = ($urandom_range(0, 7) == 0);
            vif.almost_full_D1 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 59) == 0) begin
                vif.init      = 1'b1;
                vif.weight_in = Ww'($urandom);
                step();
                step();
                vif.init = 1'b0;
            end else if ($urandom_range(0, 119) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Scheduler on the read side of the VC0/VC1 virtual-channel FIFOs.
- Decides each cycle which VC FIFO to pop, using weighted round-robin (VC0 favoured); stalls while downstream destination FIFOs are almost full.
- Forwards the popped word with a valid strobe to the downstream demux.
- Holds its own FSM (RESET/INIT/IDLE/ACTIVE); the weight is configured during INIT.

Parameters:
- data_width, 6, word width of VC FIFO data and data_out.
- weight_width, 4, width of weight_in and of the internal VC0 burst counter.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 = reset.
- init  input  1  1 = enter/stay in INIT and sample weight_in.
- weight_in  input  weight_width  max consecutive VC0 grants while VC1 waits.
- empty_VC0  input  1  VC0 FIFO empty.
- empty_VC1  input  1  VC1 FIFO empty.
- data_VC0  input  data_width  VC0 FIFO data_out; valid the cycle after its pop.
- data_VC1  input  data_width  VC1 FIFO data_out; valid the cycle after its pop.
- almost_full_D0  input  1  downstream D0 FIFO almost full.
- almost_full_D1  input  1  downstream D1 FIFO almost full.
- pop_VC0  output  1  read enable to VC0 FIFO (combinational).
- pop_VC1  output  1  read enable to VC1 FIFO (combinational).
- data_out  output  data_width  forwarded word.
- valid_out  output  1  data_out valid this cycle.
- state_out  output  2  FSM state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE.
- idle_out  output  1  1 when state is IDLE.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Registered outputs: state=RESET, valid_out=0, data_out=0, burst counter cnt=0, weight register w=1, idle_out=0.
  - pop_VC0 and pop_VC1 are forced 0 while reset=0, independent of state.
- FSM:
  - RESET -> INIT on the first edge with reset=1.
  - INIT: samples weight_in into w every cycle while init=1. A sampled value of 0 is stored as 1. Exits to IDLE on the first edge with init=0.
  - IDLE -> ACTIVE when any grant is issued.
  - ACTIVE -> IDLE when empty_VC0=1, empty_VC1=1 and no grant is issued that cycle.
  - init=1 in IDLE or ACTIVE -> INIT next edge. No grant is issued in that cycle; cnt is cleared on entry.
- Grants:
  - Grants are issued only when all hold: state is IDLE or ACTIVE, init=0, reset=1, pause=0.
  - pause = almost_full_D0 | almost_full_D1.
  - At most one pop per cycle; pop_VC0 and pop_VC1 are never both 1.
- Arbitration, with w the stored weight:
  - Both non-empty, cnt<w: pop_VC0; cnt<=cnt+1.
  - Both non-empty, cnt>=w: pop_VC1; cnt<=0.
  - Only VC0 non-empty: pop_VC0; cnt<=min(cnt+1,w), saturating at w.
  - Only VC1 non-empty: pop_VC1; cnt<=0.
  - Neither non-empty, or pause=1: no pop; cnt holds.
- Output pipeline (1-cycle latency):
  - A pop at cycle T registers vld<=1 and sel<=VC1?1:0.
  - In cycle T+1: valid_out=1 and data_out=sel?data_VC1:data_VC0.
  - data_out holds its last value when valid_out=0.
- Pause mid-stream: the word popped in the cycle before pause asserts is still delivered. Zero pops occur while pause=1.
- Reset mid-operation: any in-flight vld is discarded, so valid_out=0 the cycle after reset is sampled.
- Never pops an empty FIFO: a pop requires the matching empty_VCx=0 in the same cycle.

Optional Feature:
- Macro VC_ARB_STATS_EN.
- When defined, adds outputs grant_cnt_VC0 and grant_cnt_VC1, 8 bits each:
  - Each increments on every pop of its VC and saturates at 255.
  - Cleared by reset and on entry to INIT.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset/init: reset=0 for 2 cycles, then reset=1 with init=1 and weight_in=3 for 2 cycles, then init=0 -> state_out 0,1,1,2; pops stay 0 throughout.
- Weighted arbitration: w=3, both FIFOs hold 8 words, no pause -> pop order VC0,VC0,VC0,VC1 repeating; each valid_out follows its pop by 1 cycle with the matching FIFO word.
- Single-VC stream: w=2, only VC1 non-empty with 4 words -> 4 consecutive pop_VC1; state IDLE->ACTIVE->IDLE; idle_out=1 after the last word drains.
- Pause: almost_full_D1=1 for 3 cycles mid-stream -> zero pops during those cycles; the word popped before the pause appears on data_out; arbitration resumes with cnt unchanged.
- Weight 0 and saturation: weight_in=0 (stored as 1), VC0 only for 5 words, then VC1 becomes non-empty -> next pop is VC1, because cnt saturated at 1.
- Reset mid-stream: reset=0 while valid pipeline is 1 -> valid_out=0 next cycle, pops 0; with VC_ARB_STATS_EN, grant counters read 0.
